// File: rtl/uart_send_ctrl.sv
// rtl/uart_send_ctrl.sv - send-opcode decode, edge-accepted word FIFO and UART TX serialiser
// Optional even parity bit after the data bits when UART_SEND_PARITY_EN is defined.
module uart_send_ctrl #(
  parameter int                  OPCODE_W     = 6,
  parameter logic [OPCODE_W-1:0] OPCODE_SND   = 6'b010001,
  parameter int                  DATA_W       = 8,
  parameter int                  DEPTH        = 4,
  parameter int                  CLKS_PER_BIT = 434
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                input_sig_snd,
  input  logic [DATA_W-1:0]   data_in,
  output logic                output_sig_snd,
  output logic                snd_flag,
  output logic                tx,
  output logic                busy,
  output logic                full,
  output logic                overflow
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_SEND_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [BIT_W-1:0]  bit_idx, bit_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] head;
  logic              sig_q, accept, push, pop, empty;
`ifdef UART_SEND_PARITY_EN
  logic              par, par_n;
`endif

  assign output_sig_snd = (opcode == OPCODE_SND);
  assign accept = input_sig_snd & ~sig_q & output_sig_snd;
  // full/empty come from registered pointers, so a same-cycle pop never frees room for a push
  assign empty  = (wptr == rptr);
  assign full   = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                  (wptr[PTR_W-2:0] == rptr[PTR_W-2:0]);
  assign push   = accept & ~full;
  assign head   = mem[rptr[PTR_W-2:0]];
  assign busy   = (state != IDLE) | ~empty;

  always_ff @(posedge clock) begin
    if (push) mem[wptr[PTR_W-2:0]] <= data_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sig_q    <= 1'b0;
      snd_flag <= 1'b0;
      overflow <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
`ifdef UART_SEND_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      sig_q    <= input_sig_snd;
      snd_flag <= push;
      if (accept & full) overflow <= 1'b1;
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
`ifdef UART_SEND_PARITY_EN
      par      <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    tx      = 1'b1;
`ifdef UART_SEND_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          state_n = START;
          cnt_n   = CNT_MAX;
`ifdef UART_SEND_PARITY_EN
          par_n   = ^head;
`endif
        end
      end
      START: begin
        tx = 1'b0;
        if (cnt == '0) begin
          state_n = DATA;
          cnt_n   = CNT_MAX;
          bit_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        tx = shift[0];
        if (cnt == '0) begin
          shift_n = shift >> 1;
          cnt_n   = CNT_MAX;
          if (bit_idx == BIT_LAST) begin
`ifdef UART_SEND_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_idx + BIT_W'(1);
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
`ifdef UART_SEND_PARITY_EN
      PARITY: begin
        tx = par;
        if (cnt == '0) begin
          state_n = STOP;
          cnt_n   = CNT_MAX;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt == '0) begin
          // chain straight into the next start bit when a word is waiting
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = START;
            cnt_n   = CNT_MAX;
`ifdef UART_SEND_PARITY_EN
            par_n   = ^head;
`endif
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_send_ctrl.sv
// tb/tb_uart_send_ctrl.sv - directed scoreboard bench for uart_send_ctrl (CLKS_PER_BIT=4)
module tb_uart_send_ctrl;

  localparam int CPB = 4;
  localparam logic [5:0] SND = 6'b010001;
`ifdef UART_SEND_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       input_sig_snd;
  logic [7:0] data_in;
  logic       output_sig_snd, snd_flag, tx, busy, full, overflow;

  uart_send_ctrl #(
    .OPCODE_W(6), .OPCODE_SND(6'b010001), .DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(CPB)
  ) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .input_sig_snd(input_sig_snd),
    .data_in(data_in), .output_sig_snd(output_sig_snd), .snd_flag(snd_flag),
    .tx(tx), .busy(busy), .full(full), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         frames_rx = 0;
  int         flag_cnt = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  logic       last_par = 1'b0;
  logic       m_active = 1'b0;
  int         m_cnt = 0;
  logic [NB-1:0] m_bits;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_frame(input logic [NB-1:0] b);
    logic [7:0] w;
    chk("start_bit", b[0], 1'b0);
    chk("stop_bit", b[NB-1], 1'b1);
    chk("frame_expected", exp_q.size() > 0, 1'b1);
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("frame_data", b[8:1], w);
`ifdef UART_SEND_PARITY_EN
      chk("parity_bit", b[9], ^w);
      last_par = b[9];
`endif
    end
  endtask

  // line receiver: samples each bit in the middle of its CPB-cycle slot
  always @(negedge clock) begin
    if (snd_flag === 1'b1) flag_cnt++;
    if (reset) begin
      m_active = 1'b0;
    end else begin
      if (!m_active && tx === 1'b0) begin
        m_active = 1'b1;
        m_cnt = 0;
        starts.push_back(cyc);
      end
      if (m_active) begin
        if (m_cnt % CPB == CPB / 2) m_bits[m_cnt / CPB] = tx;
        if (m_cnt == NB * CPB - 1) begin
          m_active = 1'b0;
          frames_rx++;
          check_frame(m_bits);
        end
        m_cnt++;
      end
    end
  end

  task automatic send(input logic [7:0] w);
    data_in = w;
    input_sig_snd = 1'b1;
    exp_q.push_back(w);
    tick();
    chk("snd_flag_pulse", snd_flag, 1'b1);
    input_sig_snd = 1'b0;
    tick();
    chk("snd_flag_clear", snd_flag, 1'b0);
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    int n, f0, r0;
    reset = 1'b1;
    opcode = 6'b0;
    input_sig_snd = 1'b0;
    data_in = 8'h00;
    repeat (2) tick();
    chk("rst_tx", tx, 1'b1);
    chk("rst_snd_flag", snd_flag, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("decode_off", output_sig_snd, 1'b0);
    reset = 1'b0;
    opcode = SND;
    #1;
    chk("decode_on", output_sig_snd, 1'b1);
    tick();

    // single frame, timed from the first start-bit cycle
    send(8'h5A);
    chk("start_after_pop", tx, 1'b0);
    wait_idle(200, n);
    chk("frame_len", n, NB * CPB);
    chk("frames_single", frames_rx, 1);
    chk("queue_drained", exp_q.size(), 0);

    // strobe held high: one accept only
    f0 = flag_cnt;
    r0 = frames_rx;
    data_in = 8'h3C;
    exp_q.push_back(8'h3C);
    input_sig_snd = 1'b1;
    repeat (20) tick();
    input_sig_snd = 1'b0;
    wait_idle(200, n);
    tick();
    chk("held_flags", flag_cnt - f0, 1);
    chk("held_frames", frames_rx - r0, 1);

    // opcode mismatch: edge ignored and not replayed once the opcode matches
    f0 = flag_cnt;
    opcode = 6'b000000;
    #1;
    chk("decode_mismatch", output_sig_snd, 1'b0);
    data_in = 8'h77;
    input_sig_snd = 1'b1;
    tick();
    chk("mismatch_no_flag", snd_flag, 1'b0);
    opcode = SND;
    repeat (5) tick();
    chk("mismatch_flags", flag_cnt - f0, 0);
    chk("mismatch_tx", tx, 1'b1);
    chk("mismatch_busy", busy, 1'b0);
    input_sig_snd = 1'b0;
    tick();

    // six words during one frame: five queued back-to-back, sixth dropped
    starts.delete();
    r0 = frames_rx;
    for (int i = 1; i <= 6; i++) begin
      data_in = 8'(i);
      if (i <= 5) exp_q.push_back(8'(i));
      input_sig_snd = 1'b1;
      tick();
      chk("burst_flag", snd_flag, i <= 5);
      chk("burst_full", full, i >= 5);
      chk("burst_overflow", overflow, i == 6);
      input_sig_snd = 1'b0;
      tick();
    end
    n = 0;
    while (full && n < 100) begin
      tick();
      n++;
    end
    chk("full_released", full, 1'b0);
    wait_idle(400, n);
    tick();
    chk("burst_frames", frames_rx - r0, 5);
    chk("burst_drained", exp_q.size(), 0);
    chk("burst_starts", starts.size(), 5);
    for (int i = 1; i < 5 && i < starts.size(); i++)
      chk("no_idle_gap", starts[i] - starts[i-1], NB * CPB);
    chk("overflow_sticky", overflow, 1'b1);
    send(8'h42);
    wait_idle(200, n);
    chk("overflow_still", overflow, 1'b1);

`ifdef UART_SEND_PARITY_EN
    send(8'h07);
    wait_idle(200, n);
    chk("par_len", n, 44);
    chk("par_07", last_par, 1'b1);
    send(8'h03);
    wait_idle(200, n);
    chk("par_03", last_par, 1'b0);
`endif

    // asynchronous reset during data bit 3
    send(8'hA5);
    repeat (17) tick();
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("amid_rst_tx", tx, 1'b1);
    chk("amid_rst_busy", busy, 1'b0);
    chk("amid_rst_full", full, 1'b0);
    chk("amid_rst_overflow", overflow, 1'b0);
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    r0 = frames_rx;
    f0 = flag_cnt;
    repeat (60) begin
      tick();
      if (tx !== 1'b1) chk("post_rst_tx_idle", tx, 1'b1);
    end
    chk("post_rst_frames", frames_rx - r0, 0);
    chk("post_rst_flags", flag_cnt - f0, 0);
    chk("post_rst_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
